// File: rtl/axi_err_slave.sv
// -----------------------------------------------------------------------------
// axi_err_slave
//
// Default AXI slave that terminates every transaction with an error response.
// Write and read channels are handled by two independent FSMs, so one write
// and one read may be in flight at the same time (one outstanding of each).
// Write data is accepted and discarded. Every read beat returns zero data.
// Every response carries RESP_CODE.
//
// Optional feature: define AXI_ERR_SLAVE_CNT_EN to add the err_count port.
// err_count is a saturating 16-bit count of completed error transactions.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   awid/awlen/awvalid  write address channel in; awready out
//   wvalid / wready     write data channel (data, strobe and last unused)
//   bid/bresp/bvalid    write response out; bready in
//   arid/arlen/arvalid  read address channel in; arready out
//   rid/rdata/rresp/    read data channel out; rready in
//   rlast/rvalid
//   err_count           error transaction count (AXI_ERR_SLAVE_CNT_EN only)
// -----------------------------------------------------------------------------
module axi_err_slave #(
   parameter int         ID_W      = 8,
   parameter int         DATA_W    = 32,
   parameter int         LEN_W     = 4,
   parameter logic [1:0] RESP_CODE = 2'b11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ID_W-1:0]   awid,
   input  logic [LEN_W-1:0]  awlen,
   input  logic              awvalid,
   output logic              awready,
   input  logic              wvalid,
   output logic              wready,
   output logic [ID_W-1:0]   bid,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready,
   input  logic [ID_W-1:0]   arid,
   input  logic [LEN_W-1:0]  arlen,
   input  logic              arvalid,
   output logic              arready,
   output logic [ID_W-1:0]   rid,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        rresp,
   output logic              rlast,
   output logic              rvalid,
   input  logic              rready
`ifdef AXI_ERR_SLAVE_CNT_EN
   ,
   output logic [15:0]       err_count
`endif
);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

   wstate_t              wstate;
   rstate_t              rstate;
   logic [LEN_W-1:0]     wlen;
   logic [LEN_W-1:0]     wcnt;
   logic [LEN_W-1:0]     rlen;
   logic [LEN_W-1:0]     rcnt;
   logic [LEN_W-1:0]     rcnt_nxt;

   // Response code and read data do not depend on state.
   assign bresp = RESP_CODE;
   assign rresp = RESP_CODE;
   assign rdata = '0;

   assign rcnt_nxt = rcnt + {{(LEN_W-1){1'b0}}, 1'b1};

   // Write FSM. The last beat is detected by comparing against the captured
   // length before incrementing. The counter therefore never wraps, even
   // when awlen is all ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wstate  <= W_IDLE;
         awready <= 1'b1;
         wready  <= 1'b0;
         bvalid  <= 1'b0;
         bid     <= '0;
         wlen    <= '0;
         wcnt    <= '0;
      end else begin
         case (wstate)
            W_IDLE: begin
               if (awvalid && awready) begin
                  bid     <= awid;
                  wlen    <= awlen;
                  wcnt    <= '0;
                  awready <= 1'b0;
                  wready  <= 1'b1;
                  wstate  <= W_DATA;
               end
            end
            W_DATA: begin
               if (wvalid && wready) begin
                  if (wcnt == wlen) begin
                     wready <= 1'b0;
                     bvalid <= 1'b1;
                     wstate <= W_RESP;
                  end else begin
                     wcnt <= wcnt + {{(LEN_W-1){1'b0}}, 1'b1};
                  end
               end
            end
            W_RESP: begin
               if (bvalid && bready) begin
                  bvalid  <= 1'b0;
                  awready <= 1'b1;
                  wstate  <= W_IDLE;
               end
            end
            default: begin
               wstate  <= W_IDLE;
               awready <= 1'b1;
               wready  <= 1'b0;
               bvalid  <= 1'b0;
            end
         endcase
      end
   end

   // Read FSM. rlast is registered and is computed one beat ahead: it is
   // set on AR acceptance for single-beat bursts, and otherwise when the
   // next count reaches the captured length.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rstate  <= R_IDLE;
         arready <= 1'b1;
         rvalid  <= 1'b0;
         rlast   <= 1'b0;
         rid     <= '0;
         rlen    <= '0;
         rcnt    <= '0;
      end else begin
         case (rstate)
            R_IDLE: begin
               if (arvalid && arready) begin
                  rid     <= arid;
                  rlen    <= arlen;
                  rcnt    <= '0;
                  rlast   <= (arlen == '0);
                  rvalid  <= 1'b1;
                  arready <= 1'b0;
                  rstate  <= R_DATA;
               end
            end
            R_DATA: begin
               if (rvalid && rready) begin
                  if (rlast) begin
                     rvalid  <= 1'b0;
                     rlast   <= 1'b0;
                     arready <= 1'b1;
                     rstate  <= R_IDLE;
                  end else begin
                     rcnt  <= rcnt_nxt;
                     rlast <= (rcnt_nxt == rlen);
                  end
               end
            end
            default: begin
               rstate  <= R_IDLE;
               arready <= 1'b1;
               rvalid  <= 1'b0;
               rlast   <= 1'b0;
            end
         endcase
      end
   end

`ifdef AXI_ERR_SLAVE_CNT_EN
   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
      logic [16:0] sum;
      sum = {1'b0, a} + {15'd0, inc};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   logic       b_done;
   logic       r_done;
   logic [1:0] err_inc;

   // A B handshake and a final R handshake in the same cycle add two.
   assign b_done  = bvalid && bready;
   assign r_done  = rvalid && rready && rlast;
   assign err_inc = {1'b0, b_done} + {1'b0, r_done};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_count <= '0;
      end else begin
         err_count <= sat_add(err_count, err_inc);
      end
   end
`endif

endmodule

// File: tb/tb_axi_err_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_err_slave
//
// Self-checking bench for axi_err_slave with default parameters. Expected B
// and R responses are queued when an address is issued. They are popped and
// compared when the DUT presents the matching handshake.
// -----------------------------------------------------------------------------
module tb_axi_err_slave;

   logic        clk;
   logic        rst;
   logic [7:0]  awid;
   logic [3:0]  awlen;
   logic        awvalid;
   logic        awready;
   logic        wvalid;
   logic        wready;
   logic [7:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [7:0]  arid;
   logic [3:0]  arlen;
   logic        arvalid;
   logic        arready;
   logic [7:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
`ifdef AXI_ERR_SLAVE_CNT_EN
   logic [15:0] err_count;
`endif

   axi_err_slave dut (
      .clk(clk), .rst(rst),
      .awid(awid), .awlen(awlen), .awvalid(awvalid), .awready(awready),
      .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .arlen(arlen), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready)
`ifdef AXI_ERR_SLAVE_CNT_EN
      , .err_count(err_count)
`endif
   );

   typedef struct packed {
      logic [7:0] id;
      logic       last;
   } r_exp_t;

   logic [7:0] bq[$];
   r_exp_t     rq[$];
   int         checks = 0;
   int         errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; awid = '0; awlen = '0; awvalid = 1'b0; wvalid = 1'b0;
      bready = 1'b0; arid = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
      repeat (3) step();
      checks++; if (awready !== 1'b1) begin errors++; $display("FAIL reset_awready: got %b want 1", awready); end
      checks++; if (arready !== 1'b1) begin errors++; $display("FAIL reset_arready: got %b want 1", arready); end
      checks++; if (wready !== 1'b0) begin errors++; $display("FAIL reset_wready: got %b want 0", wready); end
      checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL reset_bvalid: got %b want 0", bvalid); end
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
      checks++; if (rlast !== 1'b0) begin errors++; $display("FAIL reset_rlast: got %b want 0", rlast); end
      checks++; if (bid !== 8'h00 || rid !== 8'h00) begin errors++; $display("FAIL reset_ids: got bid=%h rid=%h want 00 00", bid, rid); end
`ifdef AXI_ERR_SLAVE_CNT_EN
      checks++; if (err_count !== 16'h0000) begin errors++; $display("FAIL reset_err_count: got %h want 0000", err_count); end
`endif
      rst = 1'b1;
      step();
   endtask

   task automatic test_write(input logic [7:0] id, input logic [3:0] len, input int stall);
      logic [7:0] exp_id;
      logic [7:0] held;
      int         t;
      bready  = (stall == 0);
      awid    = id;
      awlen   = len;
      awvalid = 1'b1;
      bq.push_back(id);
      step();
      awvalid = 1'b0;
      checks++;
      if (wready !== 1'b1 || awready !== 1'b0) begin
         errors++; $display("FAIL wr_aw_accept: got wready=%b awready=%b want 1 0", wready, awready);
      end
      for (int i = 0; i <= int'(len); i++) begin
         wvalid = 1'b1;
         step();
         if (i < int'(len)) begin
            checks++;
            if (wready !== 1'b1 || bvalid !== 1'b0) begin
               errors++; $display("FAIL wr_beat%0d: got wready=%b bvalid=%b want 1 0", i, wready, bvalid);
            end
         end
      end
      wvalid = 1'b0;
      checks++;
      if (bvalid !== 1'b1 || wready !== 1'b0) begin
         errors++; $display("FAIL wr_b_latency: got bvalid=%b wready=%b want 1 0", bvalid, wready);
      end
      for (int s = 0; s < stall; s++) begin
         held = bid;
         step();
         checks++;
         if (bvalid !== 1'b1 || bid !== held || bresp !== 2'b11) begin
            errors++; $display("FAIL wr_b_stall: got bvalid=%b bid=%h bresp=%b want 1 %h 11", bvalid, bid, bresp, held);
         end
      end
      bready = 1'b1;
      t = 0;
      while (bvalid !== 1'b1 && t < 50) begin step(); t++; end
      if (bvalid !== 1'b1) begin
         checks++; errors++; $display("FAIL wr_b_timeout: got bvalid=%b want 1", bvalid);
      end else if (bq.size() == 0) begin
         checks++; errors++; $display("FAIL wr_b_unexpected: got bid=%h want no response", bid);
      end else begin
         exp_id = bq.pop_front();
         checks++;
         if (bid !== exp_id || bresp !== 2'b11) begin
            errors++; $display("FAIL wr_b_resp: got bid=%h bresp=%b want %h 11", bid, bresp, exp_id);
         end
      end
      step();
      bready = 1'b0;
      checks++;
      if (bvalid !== 1'b0 || awready !== 1'b1) begin
         errors++; $display("FAIL wr_b_done: got bvalid=%b awready=%b want 0 1", bvalid, awready);
      end
   endtask

   task automatic test_read(input logic [7:0] id, input logic [3:0] len, input bit toggle);
      r_exp_t e;
      int     beats;
      int     cyc;
      logic [7:0]  s_id;
      logic        s_last, s_valid;
      logic [31:0] s_data;
      for (int i = 0; i <= int'(len); i++) begin
         e.id = id; e.last = (i == int'(len));
         rq.push_back(e);
      end
      arid    = id;
      arlen   = len;
      arvalid = 1'b1;
      step();
      arvalid = 1'b0;
      checks++;
      if (arready !== 1'b0 || rvalid !== 1'b1) begin
         errors++; $display("FAIL rd_ar_accept: got arready=%b rvalid=%b want 0 1", arready, rvalid);
      end
      beats = 0;
      cyc   = 0;
      while (beats <= int'(len) && cyc < 100) begin
         rready = toggle ? (cyc % 2 == 1) : 1'b1;
         if (rready) begin
            if (rvalid === 1'b1) begin
               if (rq.size() == 0) begin
                  checks++; errors++; $display("FAIL rd_unexpected: got rid=%h want no beat", rid);
               end else begin
                  e = rq.pop_front();
                  checks++;
                  if (rid !== e.id || rlast !== e.last || rdata !== 32'h0 || rresp !== 2'b11) begin
                     errors++;
                     $display("FAIL rd_beat%0d: got rid=%h rlast=%b rdata=%h rresp=%b want %h %b 00000000 11",
                              beats, rid, rlast, rdata, rresp, e.id, e.last);
                  end
               end
               beats++;
            end
            step();
         end else begin
            s_id = rid; s_last = rlast; s_valid = rvalid; s_data = rdata;
            step();
            checks++;
            if (rid !== s_id || rlast !== s_last || rvalid !== s_valid || rdata !== s_data) begin
               errors++;
               $display("FAIL rd_stall: got rid=%h rlast=%b rvalid=%b want %h %b %b", rid, rlast, rvalid, s_id, s_last, s_valid);
            end
         end
         cyc++;
      end
      rready = 1'b0;
      checks++;
      if (beats != int'(len) + 1) begin
         errors++; $display("FAIL rd_beat_count: got %0d want %0d", beats, int'(len) + 1);
      end
      checks++;
      if (rvalid !== 1'b0 || arready !== 1'b1) begin
         errors++; $display("FAIL rd_done: got rvalid=%b arready=%b want 0 1", rvalid, arready);
      end
   endtask

   task automatic test_concurrent();
      r_exp_t e;
      logic [7:0] exp_id;
      awid = 8'h21; awlen = 4'd0; awvalid = 1'b1;
      arid = 8'h42; arlen = 4'd0; arvalid = 1'b1;
      bq.push_back(8'h21);
      e.id = 8'h42; e.last = 1'b1; rq.push_back(e);
      step();
      awvalid = 1'b0; arvalid = 1'b0;
      checks++;
      if (awready !== 1'b0 || arready !== 1'b0 || wready !== 1'b1 || rvalid !== 1'b1 || rlast !== 1'b1) begin
         errors++;
         $display("FAIL conc_accept: got awready=%b arready=%b wready=%b rvalid=%b rlast=%b want 0 0 1 1 1",
                  awready, arready, wready, rvalid, rlast);
      end
      wvalid = 1'b1; rready = 1'b1; bready = 1'b0;
      e = rq.pop_front();
      checks++;
      if (rid !== e.id || rlast !== e.last) begin
         errors++; $display("FAIL conc_r: got rid=%h rlast=%b want %h %b", rid, rlast, e.id, e.last);
      end
      step();
      wvalid = 1'b0; rready = 1'b0;
      checks++;
      if (rvalid !== 1'b0 || arready !== 1'b1 || bvalid !== 1'b1) begin
         errors++; $display("FAIL conc_mid: got rvalid=%b arready=%b bvalid=%b want 0 1 1", rvalid, arready, bvalid);
      end
      bready = 1'b1;
      exp_id = bq.pop_front();
      checks++;
      if (bid !== exp_id || bresp !== 2'b11) begin
         errors++; $display("FAIL conc_b: got bid=%h bresp=%b want %h 11", bid, bresp, exp_id);
      end
      step();
      bready = 1'b0;
      checks++;
      if (bvalid !== 1'b0 || awready !== 1'b1) begin
         errors++; $display("FAIL conc_done: got bvalid=%b awready=%b want 0 1", bvalid, awready);
      end
   endtask

   task automatic test_reset_midburst();
      awid = 8'h33; awlen = 4'd3; awvalid = 1'b1;
      step();
      awvalid = 1'b0;
      wvalid  = 1'b1;
      step();
      #2 rst = 1'b0;
      #1;
      checks++;
      if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0 || bid !== 8'h00 ||
          arready !== 1'b1 || rvalid !== 1'b0 || rlast !== 1'b0 || rid !== 8'h00) begin
         errors++;
         $display("FAIL midrst_outputs: got awready=%b wready=%b bvalid=%b bid=%h arready=%b rvalid=%b want 1 0 0 00 1 0",
                  awready, wready, bvalid, bid, arready, rvalid);
      end
      wvalid = 1'b0;
      bready = 1'b1;
      repeat (3) step();
      checks++;
      if (bvalid !== 1'b0) begin errors++; $display("FAIL midrst_no_b: got bvalid=%b want 0", bvalid); end
      bready = 1'b0;
      rst = 1'b1;
      step();
      test_write(8'hC4, 4'd1, 0);
   endtask

`ifdef AXI_ERR_SLAVE_CNT_EN
   task automatic test_err_count();
      r_exp_t e;
      logic [7:0] exp_id;
      rst = 1'b0;
      step();
      rst = 1'b1;
      step();
      checks++;
      if (err_count !== 16'd0) begin errors++; $display("FAIL cnt_clear: got %0d want 0", err_count); end
      test_write(8'h01, 4'd0, 0);
      test_write(8'h02, 4'd2, 1);
      test_read(8'h03, 4'd1, 1'b0);
      checks++;
      if (err_count !== 16'd3) begin errors++; $display("FAIL cnt_three: got %0d want 3", err_count); end
      awid = 8'h04; awlen = 4'd0; awvalid = 1'b1;
      arid = 8'h05; arlen = 4'd0; arvalid = 1'b1;
      bq.push_back(8'h04);
      e.id = 8'h05; e.last = 1'b1; rq.push_back(e);
      step();
      awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b1;
      step();
      wvalid = 1'b0; bready = 1'b1; rready = 1'b1;
      exp_id = bq.pop_front();
      e = rq.pop_front();
      checks++;
      if (bvalid !== 1'b1 || rvalid !== 1'b1 || bid !== exp_id || rid !== e.id) begin
         errors++; $display("FAIL cnt_dual: got bvalid=%b rvalid=%b bid=%h rid=%h want 1 1 %h %h",
                            bvalid, rvalid, bid, rid, exp_id, e.id);
      end
      step();
      bready = 1'b0; rready = 1'b0;
      checks++;
      if (err_count !== 16'd5) begin errors++; $display("FAIL cnt_five: got %0d want 5", err_count); end
   endtask
`endif

   initial begin
      test_reset();
      test_write(8'h5A, 4'd3, 0);
      test_write(8'hA7, 4'd2, 3);
      test_read(8'h11, 4'd2, 1'b0);
      test_read(8'h3C, 4'd15, 1'b1);
      test_write(8'hE1, 4'd15, 0);
      test_concurrent();
      test_reset_midburst();
`ifdef AXI_ERR_SLAVE_CNT_EN
      test_err_count();
`endif
      checks++;
      if (bq.size() != 0 || rq.size() != 0) begin
         errors++; $display("FAIL sb_drain: got %0d B and %0d R pending want 0 0", bq.size(), rq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
